coin_vend_ctrl: RTL and testbench

COIN_VEND_CTRL -- requirements
Module: coin_vend_ctrl

---
 rtl/vend_pkg.sv | 17 +
 rtl/edge_pulse.sv | 25 ++
 rtl/coin_vend_ctrl.sv | 124 ++++++++++++
 tb/tb_coin_vend_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the coin vending controller: FSM state encoding,
// change-coin unit and default coin values.
package vend_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_CHANGE  = 2'd3
   } vend_state_t;

   localparam int unsigned DEF_UNIT  = 5;
   localparam int unsigned DEF_VAL_A = 5;
   localparam int unsigned DEF_VAL_B = 10;
   localparam int unsigned DEF_VAL_C = 20;

endpackage

// File: rtl/edge_pulse.sv
// Two-flop synchroniser with rising-edge detect: one pulse per rising level
// of din, however long it is held.
module edge_pulse (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic pulse
);

   logic d1;
   logic d2;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         d1 <= '0;
         d2 <= '0;
      end else begin
         d1 <= din;
         d2 <= d1;
      end
   end

   assign pulse = d1 & ~d2;

endmodule

// File: rtl/coin_vend_ctrl.sv
// Coin vending controller: synchronised coin/cancel edges feed a credit
// datapath and IDLE/COLLECT/VEND/CHANGE FSM with registered outputs.
module coin_vend_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned PRICE      = 25,
   parameter int unsigned UNIT       = DEF_UNIT,
   parameter int unsigned VAL_A      = DEF_VAL_A,
   parameter int unsigned VAL_B      = DEF_VAL_B,
   parameter int unsigned VAL_C      = DEF_VAL_C,
   parameter int unsigned MAX_CREDIT = 60,
   parameter int unsigned CW         = 7
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          coin_a,
   input  logic          coin_b,
   input  logic          coin_c,
   input  logic          cancel,
   input  logic          chg_ready,
   output logic          product_release,
   output logic          change_pulse,
   output logic          coin_reject,
   output logic [CW-1:0] credit,
   output logic          busy
);

   localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
   localparam logic [CW-1:0] UNIT_C  = CW'(UNIT);
   localparam logic [CW-1:0] MAX_C   = CW'(MAX_CREDIT);
   localparam logic [CW-1:0] VAL_A_C = CW'(VAL_A);
   localparam logic [CW-1:0] VAL_B_C = CW'(VAL_B);
   localparam logic [CW-1:0] VAL_C_C = CW'(VAL_C);

   logic p_a, p_b, p_c, p_cancel;

   edge_pulse u_ep_a      (.clk(clk), .rstn(rstn), .din(coin_a), .pulse(p_a));
   edge_pulse u_ep_b      (.clk(clk), .rstn(rstn), .din(coin_b), .pulse(p_b));
   edge_pulse u_ep_c      (.clk(clk), .rstn(rstn), .din(coin_c), .pulse(p_c));
   edge_pulse u_ep_cancel (.clk(clk), .rstn(rstn), .din(cancel), .pulse(p_cancel));

   vend_state_t   state, state_nx;
   logic [CW-1:0] credit_nx;
   logic          prod_nx, chg_nx, rej_nx, busy_nx;
   logic          coin_any;
   logic [CW-1:0] coin_sum, credit_sum, credit_dec;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= S_IDLE;
         credit          <= '0;
         product_release <= 1'b0;
         change_pulse    <= 1'b0;
         coin_reject     <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state           <= state_nx;
         credit          <= credit_nx;
         product_release <= prod_nx;
         change_pulse    <= chg_nx;
         coin_reject     <= rej_nx;
         busy            <= busy_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      credit_nx  = credit;
      chg_nx     = 1'b0;
      rej_nx     = 1'b0;
      coin_any   = p_a | p_b | p_c;
      coin_sum   = (p_a ? VAL_A_C : '0) + (p_b ? VAL_B_C : '0) + (p_c ? VAL_C_C : '0);
      credit_sum = credit + coin_sum;
      credit_dec = credit - UNIT_C;

      case (state)
         S_IDLE, S_COLLECT: begin
            if (state == S_IDLE) begin
               credit_nx = '0;
            end
            // Cancel only counts once credit exists; it then overrides any coin.
            if (state == S_COLLECT && p_cancel) begin
               state_nx = S_CHANGE;
               rej_nx   = coin_any;
            end else if (coin_any) begin
               if (credit_sum > MAX_C) begin
                  rej_nx = 1'b1;
               end else if (credit_sum >= PRICE_C) begin
                  state_nx  = S_VEND;
                  credit_nx = credit_sum - PRICE_C;
               end else begin
                  state_nx  = S_COLLECT;
                  credit_nx = credit_sum;
               end
            end
         end
         S_VEND: begin
            rej_nx   = coin_any;
            state_nx = (credit != '0) ? S_CHANGE : S_IDLE;
         end
         S_CHANGE: begin
            rej_nx = coin_any;
            if (credit < UNIT_C) begin
               credit_nx = '0;
               state_nx  = S_IDLE;
            end else if (chg_ready) begin
               chg_nx    = 1'b1;
               credit_nx = credit_dec;
               if (credit_dec == '0) begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: begin
            state_nx  = S_IDLE;
            credit_nx = '0;
         end
      endcase

      prod_nx = (state_nx == S_VEND);
      busy_nx = (state_nx == S_VEND) || (state_nx == S_CHANGE);
   end

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Scoreboard bench: stimulus pushes expected output events, per-DUT monitors
// pop and compare them whenever an output pulse appears.
module tb_coin_vend_ctrl;

   localparam int CW      = 7;
   localparam int EV_PROD = 0;
   localparam int EV_CHG  = 1;
   localparam int EV_REJ  = 2;

   typedef struct {
      int kind;
      int cr;
   } ev_t;

   logic clk = 1'b0;
   logic rstn;
   logic coin_a, coin_b, coin_c, cancel, chg_ready;
   logic product_release, change_pulse, coin_reject, busy;
   logic [CW-1:0] credit;

   logic coin2_a, coin2_b, coin2_c, cancel2, chg_ready2;
   logic product_release2, change_pulse2, coin_reject2, busy2;
   logic [CW-1:0] credit2;

   ev_t q0[$];
   ev_t q1[$];
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   coin_vend_ctrl u_dut (
      .clk(clk), .rstn(rstn), .coin_a(coin_a), .coin_b(coin_b), .coin_c(coin_c),
      .cancel(cancel), .chg_ready(chg_ready), .product_release(product_release),
      .change_pulse(change_pulse), .coin_reject(coin_reject), .credit(credit), .busy(busy)
   );

   coin_vend_ctrl #(.PRICE(60)) u_dut_hi (
      .clk(clk), .rstn(rstn), .coin_a(coin2_a), .coin_b(coin2_b), .coin_c(coin2_c),
      .cancel(cancel2), .chg_ready(chg_ready2), .product_release(product_release2),
      .change_pulse(change_pulse2), .coin_reject(coin_reject2), .credit(credit2), .busy(busy2)
   );

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   task automatic expect_ev(input int d, input int kind, input int cr);
      ev_t e;
      e.kind = kind;
      e.cr   = cr;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic pop_cmp(input int d, input int kind, input int cr);
      ev_t e;
      checks++;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
         errors++;
         $display("FAIL dut%0d unexpected_event: got kind %0d credit %0d expected none", d, kind, cr);
      end else begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         if (e.kind != kind || e.cr != cr) begin
            errors++;
            $display("FAIL dut%0d event: got kind %0d credit %0d expected kind %0d credit %0d",
                     d, kind, cr, e.kind, e.cr);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (product_release) pop_cmp(0, EV_PROD, int'(credit));
         if (change_pulse)    pop_cmp(0, EV_CHG,  int'(credit));
         if (coin_reject)     pop_cmp(0, EV_REJ,  int'(credit));
         if (product_release2) pop_cmp(1, EV_PROD, int'(credit2));
         if (change_pulse2)    pop_cmp(1, EV_CHG,  int'(credit2));
         if (coin_reject2)     pop_cmp(1, EV_REJ,  int'(credit2));
      end
   end

   task automatic set_in(input int d, input int which, input logic v);
      if (d == 0) begin
         case (which)
            0: coin_a = v;
            1: coin_b = v;
            2: coin_c = v;
            default: cancel = v;
         endcase
      end else begin
         case (which)
            0: coin2_a = v;
            1: coin2_b = v;
            2: coin2_c = v;
            default: cancel2 = v;
         endcase
      end
   endtask

   // which: 0=A, 1=B, 2=C, 3=cancel
   task automatic press(input int d, input int which);
      @(negedge clk);
      set_in(d, which, 1'b1);
      repeat (4) @(negedge clk);
      set_in(d, which, 1'b0);
      repeat (4) @(negedge clk);
   endtask

   task automatic settle();
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation still running");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int seen;
      rstn = 1'b0;
      {coin_a, coin_b, coin_c, cancel} = '0;
      {coin2_a, coin2_b, coin2_c, cancel2} = '0;
      chg_ready  = 1'b1;
      chg_ready2 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_credit", int'(credit), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pulses", int'({product_release, change_pulse, coin_reject}), 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // B,B,A: exact price
      expect_ev(0, EV_PROD, 0);
      press(0, 1);
      chk("bba_credit_10", int'(credit), 10);
      press(0, 1);
      chk("bba_credit_20", int'(credit), 20);
      press(0, 0);
      settle();
      chk("bba_credit_end", int'(credit), 0);
      chk("bba_busy_end", int'(busy), 0);

      // C,B: one unit of change
      expect_ev(0, EV_PROD, 5);
      expect_ev(0, EV_CHG, 0);
      press(0, 2);
      chk("cb_credit_20", int'(credit), 20);
      press(0, 1);
      settle();
      chk("cb_credit_end", int'(credit), 0);

      // A,B then cancel: full refund
      press(0, 0);
      press(0, 1);
      chk("cancel_credit_15", int'(credit), 15);
      expect_ev(0, EV_CHG, 10);
      expect_ev(0, EV_CHG, 5);
      expect_ev(0, EV_CHG, 0);
      press(0, 3);
      settle();
      chk("cancel_credit_end", int'(credit), 0);
      chk("cancel_busy_end", int'(busy), 0);

      // cancel and coin B in the same cycle: cancel wins, coin rejected
      press(0, 0);
      chk("cancel_coin_credit_5", int'(credit), 5);
      expect_ev(0, EV_REJ, 5);
      expect_ev(0, EV_CHG, 0);
      @(negedge clk);
      cancel = 1'b1;
      coin_b = 1'b1;
      repeat (4) @(negedge clk);
      cancel = 1'b0;
      coin_b = 1'b0;
      settle();
      chk("cancel_coin_credit_end", int'(credit), 0);

      // A and B together: summed, no reject
      @(negedge clk);
      coin_a = 1'b1;
      coin_b = 1'b1;
      repeat (4) @(negedge clk);
      coin_a = 1'b0;
      coin_b = 1'b0;
      repeat (4) @(negedge clk);
      chk("ab_same_credit_15", int'(credit), 15);
      expect_ev(0, EV_PROD, 10);
      expect_ev(0, EV_CHG, 5);
      expect_ev(0, EV_CHG, 0);
      press(0, 2);
      settle();
      chk("ab_same_credit_end", int'(credit), 0);

      // C,C with dispenser stalled, coin during CHANGE, reset mid-change
      chg_ready = 1'b0;
      press(0, 2);
      expect_ev(0, EV_PROD, 15);
      press(0, 2);
      expect_ev(0, EV_REJ, 15);
      press(0, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_busy", int'(busy), 1);
         chk("stall_credit", int'(credit), 15);
      end
      expect_ev(0, EV_CHG, 10);
      chg_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (change_pulse) seen = 1;
      end
      chk("stall_first_change_seen", seen, 1);
      #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_credit", int'(credit), 0);
      chk("midreset_busy", int'(busy), 0);
      rstn = 1'b1;
      settle();
      chk("postreset_credit", int'(credit), 0);
      chk("postreset_busy", int'(busy), 0);

      // coin held through reset release: exactly one credit
      @(negedge clk);
      rstn = 1'b0;
      coin_a = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      chk("held_coin_credit", int'(credit), 5);
      coin_a = 1'b0;
      repeat (4) @(negedge clk);
      chk("held_coin_credit_once", int'(credit), 5);
      expect_ev(0, EV_CHG, 0);
      press(0, 3);
      settle();
      chk("held_coin_refund", int'(credit), 0);

      // PRICE=60 instance: ceiling rejection and accept-at-ceiling
      press(1, 2);
      press(1, 2);
      press(1, 1);
      chk("ceiling_credit_50", int'(credit2), 50);
      expect_ev(1, EV_REJ, 50);
      press(1, 2);
      chk("ceiling_reject_keeps_50", int'(credit2), 50);
      press(1, 0);
      chk("ceiling_credit_55", int'(credit2), 55);
      expect_ev(1, EV_PROD, 0);
      press(1, 0);
      settle();
      chk("ceiling_credit_end", int'(credit2), 0);
      chk("ceiling_busy_end", int'(busy2), 0);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
